cc_burst_serializer: RTL

Parametrised line-to-beat serializer between the cache-controller response FIFO and the interconnect read-data channel. Pops one tagged cache line per FIFO entry and emits it as an R-channel burst in either wrap (critical-word-first) or incrementing order. Holds two lines in a ping-pong buffer so consecutive bursts leave the block with no idle cycle between them.

---
 rtl/cc_ser_pkg.sv | 26 ++
 rtl/cc_burst_serializer_if.sv | 28 ++
 rtl/cc_ser_slot.sv | 41 ++++
 rtl/cc_burst_serializer.sv | 85 ++++++++
 4 files changed

// File: rtl/cc_ser_pkg.sv
// rtl/cc_ser_pkg.sv - shared defaults, slot layout and burst-length helpers for cc_burst_serializer
package cc_ser_pkg;

  localparam int DEF_LINE_W = 512;
  localparam int DEF_BEAT_W = 64;
  localparam int DEF_ID_W   = 4;

  function automatic int ofs_w(input int line_w, input int beat_w);
    return $clog2(line_w / beat_w);
  endfunction

  localparam int DEF_OFS_W = ofs_w(DEF_LINE_W, DEF_BEAT_W);

  // Matches the FIFO word layout {id, wrap, start_beat, line} for the default sizes.
  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic                  wrap;
    logic [DEF_OFS_W-1:0]  start;
    logic [DEF_LINE_W-1:0] line;
  } slot_t;

  function automatic int burst_len(input int beats, input logic wrap, input int start);
    return wrap ? beats : beats - start;
  endfunction

endpackage

// File: rtl/cc_burst_serializer_if.sv
// rtl/cc_burst_serializer_if.sv - response-FIFO pop side and R-channel beat side of the serializer
interface cc_burst_serializer_if #(
  parameter int LINE_W = cc_ser_pkg::DEF_LINE_W,
  parameter int BEAT_W = cc_ser_pkg::DEF_BEAT_W,
  parameter int ID_W   = cc_ser_pkg::DEF_ID_W
);
  localparam int OFS_W  = cc_ser_pkg::ofs_w(LINE_W, BEAT_W);
  localparam int FIFO_W = ID_W + 1 + OFS_W + LINE_W;

  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_rdata;
  logic              fifo_rden;
  logic [ID_W-1:0]   rid;
  logic [BEAT_W-1:0] rdata;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    input  fifo_empty, fifo_rdata, rready,
    output fifo_rden, rid, rdata, rlast, rvalid
  );

  modport slave (
    output fifo_empty, fifo_rdata, rready,
    input  fifo_rden, rid, rdata, rlast, rvalid
  );
endinterface

// File: rtl/cc_ser_slot.sv
// rtl/cc_ser_slot.sv - one ping-pong entry: holds a tagged line and selects beat (start+cnt) mod BEATS
module cc_ser_slot
  import cc_ser_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int ID_W   = DEF_ID_W,
  parameter int OFS_W  = ofs_w(LINE_W, BEAT_W)
) (
  input  logic                            clk,
  input  logic                            load_i,
  input  logic [ID_W+1+OFS_W+LINE_W-1:0]  word_i,
  input  logic [OFS_W-1:0]                cnt_i,
  output logic [ID_W-1:0]                 id_o,
  output logic                            wrap_o,
  output logic [OFS_W-1:0]                start_o,
  output logic [BEAT_W-1:0]               beat_o
);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              wrap;
    logic [OFS_W-1:0]  start;
    logic [LINE_W-1:0] line;
  } entry_t;

  entry_t           slot_q;
  logic [OFS_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (load_i) slot_q <= word_i;
  end

  // OFS_W-bit add wraps naturally at BEATS.
  assign idx     = slot_q.start + cnt_i;
  assign beat_o  = slot_q.line[idx*BEAT_W +: BEAT_W];
  assign id_o    = slot_q.id;
  assign wrap_o  = slot_q.wrap;
  assign start_o = slot_q.start;

endmodule

// File: rtl/cc_burst_serializer.sv
// rtl/cc_burst_serializer.sv - pops tagged cache lines and emits them as wrap/incr R-channel bursts
module cc_burst_serializer
  import cc_ser_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int ID_W   = DEF_ID_W
) (
  input  logic                  clk,
  input  logic                  rst,
  cc_burst_serializer_if.master bus
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int OFS_W = ofs_w(LINE_W, BEAT_W);

  logic [1:0]       occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [OFS_W:0]   cnt_q, cnt_d;

  logic             pop, rvalid, hs, last, done;
  logic [ID_W-1:0]  id_s    [2];
  logic             wrap_s  [2];
  logic [OFS_W-1:0] start_s [2];
  logic [BEAT_W-1:0] beat_s [2];

  for (genvar g = 0; g < 2; g++) begin : g_slot
    cc_ser_slot #(
      .LINE_W(LINE_W), .BEAT_W(BEAT_W), .ID_W(ID_W), .OFS_W(OFS_W)
    ) u_slot (
      .clk    (clk),
      .load_i (pop && (wr_ptr_q == 1'(g))),
      .word_i (bus.fifo_rdata),
      .cnt_i  (cnt_q[OFS_W-1:0]),
      .id_o   (id_s[g]),
      .wrap_o (wrap_s[g]),
      .start_o(start_s[g]),
      .beat_o (beat_s[g])
    );
  end

  // rst gates the outputs so nothing is popped or presented while reset is held.
  assign pop    = !rst && !bus.fifo_empty && (occ_q < 2'd2);
  assign rvalid = !rst && (occ_q != 2'd0);
  assign hs     = rvalid && bus.rready;
  assign last   = (int'(cnt_q) ==
                   burst_len(BEATS, wrap_s[rd_ptr_q], int'(start_s[rd_ptr_q])) - 1);
  assign done   = hs && last;

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (pop) wr_ptr_d = ~wr_ptr_q;
    if (hs)  cnt_d = cnt_q + 1'b1;
    if (done) begin
      cnt_d    = '0;
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, pop} - {1'b0, done};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.fifo_rden = pop;
  assign bus.rvalid    = rvalid;
  assign bus.rlast     = rvalid && last;
  assign bus.rid       = rvalid ? id_s[rd_ptr_q] : '0;
  assign bus.rdata     = rvalid ? beat_s[rd_ptr_q] : '0;

endmodule
